// File: rtl/gpio_output_pkg.sv
// Shared definitions for the TX digital GPIO output path: register address,
// configuration field layout, source-select codes and FSM states.
package gpio_output_pkg;

   // Setting-bus address of the TX GPIO output configuration register
   localparam logic [6:0] SR_GPIO_OUTPUT = 7'd80;

   // Configuration field layout (bits [31:21] of the bus word are ignored)
   localparam int unsigned CFG_W     = 21;
   localparam int unsigned PINS      = 4;   // pin order A14, A15, B14, B15
   localparam int unsigned SRC_LSB   = 0;
   localparam int unsigned SRC_W     = 2;
   localparam int unsigned OE_LSB    = 8;
   localparam int unsigned IDLE_LSB  = 12;
   localparam int unsigned DELAY_LSB = 16;
   localparam int unsigned DELAY_W   = 5;

   // Which TX stream bit drives a pin
   typedef enum logic [1:0] {
      SRC_DIG0_I = 2'd0,
      SRC_DIG0_Q = 2'd1,
      SRC_DIG1_I = 2'd2,
      SRC_DIG1_Q = 2'd3
   } src_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN
   } state_e;

   // bits = {dig1_q, dig1_i, dig0_q, dig0_i}
   function automatic logic pick_src(input src_sel_e sel, input logic [3:0] bits);
      logic r;
      r = bits[0];
      case (sel)
         SRC_DIG0_I: r = bits[0];
         SRC_DIG0_Q: r = bits[1];
         SRC_DIG1_I: r = bits[2];
         SRC_DIG1_Q: r = bits[3];
         default:    r = bits[0];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gpio_output_delay_line.sv
// Strobe-enabled 4-bit shift register with a variable tap. Tap 0 is the
// live input; tap N>0 is the sample captured N strobes earlier (read
// before the shift on the same strobe).
module gpio_delay_line #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned SEL_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift,
   input  logic [3:0]       din,
   input  logic [SEL_W-1:0] sel,
   output logic [3:0]       tap
);

   logic [3:0] line [DEPTH];

   // Shift on strobe; clear has priority over shift
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) line[i] <= '0;
      end else if (clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) line[i] <= '0;
      end else if (shift) begin
         line[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) line[i] <= line[i-1];
      end
   end

   // Tap select: live input for zero delay, else stored entry
   always_comb begin
      tap = din;
      if (sel != '0) tap = line[sel - 1'b1];
   end

endmodule

// File: rtl/gpio_output.sv
// TX digital GPIO output: routes the digital bits of the TX sample stream
// onto daughterboard pins 14/15 of sides A and B through a programmable
// strobe-count delay so pin edges line up with the DAC analog path.
module gpio_output
   import gpio_output_pkg::*;
#(
   parameter logic [6:0]  SR_ADDR   = SR_GPIO_OUTPUT,
   parameter int unsigned MAX_DELAY = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        tx_strobe,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   input  logic        serial_strobe,
   input  logic        tx_dig0_i,
   input  logic        tx_dig0_q,
   input  logic        tx_dig1_i,
   input  logic        tx_dig1_q,
   output logic [1:0]  tx_a_dig,
   output logic [1:0]  tx_b_dig,
   output logic [1:0]  tx_a_oe,
   output logic [1:0]  tx_b_oe
);

   logic [CFG_W-1:0]   cfg;
   logic               cfg_wr;
   logic               d_change;
   logic [DELAY_W-1:0] delay;
   logic [PINS-1:0]    idle_lvl;
   logic [PINS-1:0]    oe;
   logic [3:0]         din;
   logic [3:0]         tap;
   logic [PINS-1:0]    run_bits;
   logic [PINS-1:0]    out_reg;
   logic [PINS-1:0]    pins;
   logic [DELAY_W-1:0] fill_cnt, fill_nxt;
   logic               line_clear, line_shift;
   logic               unused_data;
   state_e             state, state_nxt;

   assign unused_data = ^serial_data[31:CFG_W];

   assign cfg_wr   = serial_strobe && (serial_addr == SR_ADDR);
   assign delay    = cfg[DELAY_LSB +: DELAY_W];
   assign d_change = cfg_wr && (serial_data[DELAY_LSB +: DELAY_W] != delay);
   assign idle_lvl = cfg[IDLE_LSB +: PINS];
   assign oe       = cfg[OE_LSB +: PINS];
   assign din      = {tx_dig1_q, tx_dig1_i, tx_dig0_q, tx_dig0_i};

   // Configuration register, takes effect the clock after the write
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       cfg <= '0;
      else if (cfg_wr) cfg <= serial_data[CFG_W-1:0];
   end

   // FSM state and fill counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         fill_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fill_cnt <= fill_nxt;
      end
   end

   // Next-state logic: enable low dominates, then delay rewrites, then fill progress
   always_comb begin
      state_nxt = state;
      fill_nxt  = fill_cnt;
      if (!enable) begin
         state_nxt = ST_IDLE;
         fill_nxt  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_FILL;
               fill_nxt  = '0;
            end
            ST_FILL: begin
               if (d_change) begin
                  fill_nxt = '0;
               end else if (fill_cnt == delay) begin
                  state_nxt = ST_RUN;
               end else if (tx_strobe && (fill_cnt != '1)) begin
                  fill_nxt = fill_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (d_change) begin
                  state_nxt = ST_FILL;
                  fill_nxt  = '0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               fill_nxt  = '0;
            end
         endcase
      end
   end

   // Line is wiped on every clock that lands in IDLE, including the entry edge
   assign line_clear = (state_nxt == ST_IDLE);
   assign line_shift = tx_strobe && enable && (state != ST_IDLE);

   gpio_delay_line #(
      .DEPTH (MAX_DELAY),
      .SEL_W (DELAY_W)
   ) u_line (
      .clock (clock),
      .reset (reset),
      .clear (line_clear),
      .shift (line_shift),
      .din   (din),
      .sel   (delay),
      .tap   (tap)
   );

   // Per-pin source mux applied to the delayed tap
   always_comb begin
      run_bits = '0;
      for (int unsigned p = 0; p < PINS; p++)
         run_bits[p] = pick_src(src_sel_e'(cfg[SRC_LSB + SRC_W*p +: SRC_W]), tap);
   end

   // Output register: preloaded with idle levels outside RUN so RUN starts idle
   // until its first strobe; loads tap data on strobes while running
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                       out_reg <= '0;
      else if (state != ST_RUN)        out_reg <= idle_lvl;
      else if (enable && tx_strobe)    out_reg <= run_bits;
   end

   // Outside RUN the pins follow the idle levels directly so level changes and
   // state exits show on the same edge that causes them
   assign pins     = (state == ST_RUN) ? out_reg : idle_lvl;
   assign tx_a_dig = pins[1:0];
   assign tx_b_dig = pins[3:2];
   assign tx_a_oe  = oe[1:0];
   assign tx_b_oe  = oe[3:2];

endmodule

// File: tb/tb_gpio_output.sv
module tb_gpio_output;

   localparam logic [6:0] SR = 7'd80;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        tx_strobe = 1'b0;
   logic [6:0]  serial_addr = '0;
   logic [31:0] serial_data = '0;
   logic        serial_strobe = 1'b0;
   logic        tx_dig0_i = 1'b0, tx_dig0_q = 1'b0, tx_dig1_i = 1'b0, tx_dig1_q = 1'b0;
   logic [1:0]  tx_a_dig, tx_b_dig, tx_a_oe, tx_b_oe;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] sb [$];     // scoreboard of expected {B15,B14,A15,A14}
   logic [3:0] hist [$];   // samples presented on strobes
   logic [3:0] last_exp;
   logic [3:0] e;
   logic [3:0] s;

   always #5 clock = ~clock;

   gpio_output #(.SR_ADDR(SR), .MAX_DELAY(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .tx_strobe     (tx_strobe),
      .serial_addr   (serial_addr),
      .serial_data   (serial_data),
      .serial_strobe (serial_strobe),
      .tx_dig0_i     (tx_dig0_i),
      .tx_dig0_q     (tx_dig0_q),
      .tx_dig1_i     (tx_dig1_i),
      .tx_dig1_q     (tx_dig1_q),
      .tx_a_dig      (tx_a_dig),
      .tx_b_dig      (tx_b_dig),
      .tx_a_oe       (tx_a_oe),
      .tx_b_oe       (tx_b_oe)
   );

   // Expected pins {B15,B14,A15,A14} from source fields and a sample {d1q,d1i,d0q,d0i}
   function automatic logic [3:0] map_pins(input logic [7:0] srcs, input logic [3:0] smp);
      logic [3:0] r;
      for (int p = 0; p < 4; p++) r[p] = smp[srcs[2*p +: 2]];
      return r;
   endfunction

   function automatic logic [3:0] pins_now();
      return {tx_b_dig, tx_a_dig};
   endfunction

   function automatic logic [3:0] oe_now();
      return {tx_b_oe, tx_a_oe};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_sample(input logic [3:0] smp);
      {tx_dig1_q, tx_dig1_i, tx_dig0_q, tx_dig0_i} = smp;
   endtask

   task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
      serial_addr   = a;
      serial_data   = d;
      serial_strobe = 1'b1;
      tick();
      serial_strobe = 1'b0;
   endtask

   task automatic strobe_edge();
      tx_strobe = 1'b1;
      tick();
      tx_strobe = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (pins_now() !== 4'h0) begin n_fail++; $display("FAIL reset_dig got %b want 0000", pins_now()); end
      n_checks++;
      if (oe_now() !== 4'h0) begin n_fail++; $display("FAIL reset_oe got %b want 0000", oe_now()); end
      reset = 1'b0;
      tick();
      n_checks++;
      if (pins_now() !== 4'h0) begin n_fail++; $display("FAIL post_reset_dig got %b want 0000", pins_now()); end
      n_checks++;
      if (oe_now() !== 4'h0) begin n_fail++; $display("FAIL post_reset_oe got %b want 0000", oe_now()); end
   endtask

   // D=0: pins follow each strobe one clock later and hold in between
   task automatic test_d0();
      logic [3:0] pat [3];
      pat[0] = 4'b1001; pat[1] = 4'b0100; pat[2] = 4'b1101;
      write_reg(SR, 32'h0000_0FE4);
      n_checks++;
      if (oe_now() !== 4'hF) begin n_fail++; $display("FAIL d0_oe got %b want 1111", oe_now()); end
      enable = 1'b1;
      repeat (2) tick();
      last_exp = 4'h0;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(map_pins(8'hE4, pat[k]));
         set_sample(pat[k]);
         n_checks++;
         if (pins_now() !== last_exp) begin n_fail++; $display("FAIL d0_lag k=%0d got %b want %b", k, pins_now(), last_exp); end
         strobe_edge();
         e = sb.pop_front();
         n_checks++;
         if (pins_now() !== e) begin n_fail++; $display("FAIL d0_data k=%0d got %b want %b", k, pins_now(), e); end
         last_exp = e;
         repeat (3) tick();
         n_checks++;
         if (pins_now() !== last_exp) begin n_fail++; $display("FAIL d0_hold k=%0d got %b want %b", k, pins_now(), last_exp); end
      end
      n_checks++;
      if (tx_a_oe !== 2'b11) begin n_fail++; $display("FAIL d0_a_oe got %b want 11", tx_a_oe); end
   endtask

   // D=3, walking one on dig1_i routed to B14
   task automatic test_delay3();
      enable = 1'b0;
      tick();
      write_reg(SR, 32'h0003_6FE4);
      n_checks++;
      if (pins_now() !== 4'b0110) begin n_fail++; $display("FAIL d3_idle got %b want 0110", pins_now()); end
      last_exp = 4'b0110;
      enable = 1'b1;
      tick();
      hist.delete();
      for (int k = 0; k < 9; k++) begin
         s = 4'($urandom_range(0, 15));
         s[2] = (k % 4 == 0);
         hist.push_back(s);
         if (k < 3) sb.push_back(4'b0110);
         else       sb.push_back(map_pins(8'hE4, hist[k-3]));
         set_sample(s);
         n_checks++;
         if (pins_now() !== last_exp) begin n_fail++; $display("FAIL d3_hold k=%0d got %b want %b", k, pins_now(), last_exp); end
         strobe_edge();
         e = sb.pop_front();
         n_checks++;
         if (pins_now() !== e) begin n_fail++; $display("FAIL d3_data k=%0d got %b want %b", k, pins_now(), e); end
         last_exp = e;
         repeat (3) tick();
      end
   endtask

   // Enable drop in RUN with a simultaneous strobe, then refill after re-enable
   task automatic test_enable_drop();
      write_reg(SR, 32'h0003_AFE4);
      n_checks++;
      if (pins_now() !== last_exp) begin n_fail++; $display("FAIL drop_samed got %b want %b", pins_now(), last_exp); end
      set_sample(4'b1111);
      enable = 1'b0;
      strobe_edge();
      n_checks++;
      if (pins_now() !== 4'b1010) begin n_fail++; $display("FAIL drop_idle got %b want 1010", pins_now()); end
      n_checks++;
      if (oe_now() !== 4'hF) begin n_fail++; $display("FAIL drop_oe got %b want 1111", oe_now()); end
      last_exp = 4'b1010;
      repeat (2) tick();
      enable = 1'b1;
      tick();
      hist.delete();
      for (int k = 0; k < 6; k++) begin
         s = 4'($urandom_range(0, 15));
         hist.push_back(s);
         if (k < 3) sb.push_back(4'b1010);
         else       sb.push_back(map_pins(8'hE4, hist[k-3]));
         set_sample(s);
         n_checks++;
         if (pins_now() !== last_exp) begin n_fail++; $display("FAIL refill_hold k=%0d got %b want %b", k, pins_now(), last_exp); end
         strobe_edge();
         e = sb.pop_front();
         n_checks++;
         if (pins_now() !== e) begin n_fail++; $display("FAIL refill_data k=%0d got %b want %b", k, pins_now(), e); end
         last_exp = e;
         repeat (3) tick();
      end
   endtask

   // D 3->1 rewrite in RUN, then a same-value rewrite that must not glitch
   task automatic test_d_rewrite();
      write_reg(SR, 32'h0001_AFE4);
      n_checks++;
      if (pins_now() !== 4'b1010) begin n_fail++; $display("FAIL rewrite_idle got %b want 1010", pins_now()); end
      last_exp = 4'b1010;
      hist.delete();
      for (int k = 0; k < 7; k++) begin
         if (k == 4) begin
            write_reg(SR, 32'h0001_AFE4);
            n_checks++;
            if (pins_now() !== last_exp) begin n_fail++; $display("FAIL same_d_glitch got %b want %b", pins_now(), last_exp); end
            tick();
         end
         s = 4'($urandom_range(0, 15));
         if (k == 0) sb.push_back(4'b1010);
         else        sb.push_back(map_pins(8'hE4, hist[$]));
         hist.push_back(s);
         set_sample(s);
         strobe_edge();
         e = sb.pop_front();
         n_checks++;
         if (pins_now() !== e) begin n_fail++; $display("FAIL rewrite_data k=%0d got %b want %b", k, pins_now(), e); end
         last_exp = e;
         repeat (3) tick();
      end
   endtask

   // Foreign address ignored; A14 source swap applies from the next strobe
   task automatic test_other_addr_and_swap();
      write_reg(SR + 7'd1, 32'hFFFF_FFFF);
      tick();
      n_checks++;
      if (pins_now() !== last_exp) begin n_fail++; $display("FAIL other_addr_dig got %b want %b", pins_now(), last_exp); end
      n_checks++;
      if (oe_now() !== 4'hF) begin n_fail++; $display("FAIL other_addr_oe got %b want 1111", oe_now()); end
      // known sample with dig0_i=0, dig1_q=1 so the swap is visible on A14
      sb.push_back(map_pins(8'hE4, hist[$]));
      hist.push_back(4'b1000);
      set_sample(4'b1000);
      strobe_edge();
      e = sb.pop_front();
      n_checks++;
      if (pins_now() !== e) begin n_fail++; $display("FAIL other_addr_mux got %b want %b", pins_now(), e); end
      last_exp = e;
      repeat (3) tick();
      write_reg(SR, 32'h0001_AFE7);
      n_checks++;
      if (pins_now() !== last_exp) begin n_fail++; $display("FAIL swap_early got %b want %b", pins_now(), last_exp); end
      sb.push_back(map_pins(8'hE7, hist[$]));
      hist.push_back(4'b1010);
      set_sample(4'b1010);
      strobe_edge();
      e = sb.pop_front();
      n_checks++;
      if (pins_now() !== e) begin n_fail++; $display("FAIL swap_data got %b want %b", pins_now(), e); end
      repeat (3) tick();
   endtask

   // Asynchronous reset mid-cycle while A pins are driven high
   task automatic test_async_reset();
      set_sample(4'b1010);
      strobe_edge();
      repeat (3) tick();
      n_checks++;
      if (tx_a_dig !== 2'b11) begin n_fail++; $display("FAIL pre_reset_a got %b want 11", tx_a_dig); end
      #2;
      reset  = 1'b1;
      enable = 1'b0;
      #1;
      n_checks++;
      if (pins_now() !== 4'h0) begin n_fail++; $display("FAIL async_reset_dig got %b want 0000", pins_now()); end
      n_checks++;
      if (oe_now() !== 4'h0) begin n_fail++; $display("FAIL async_reset_oe got %b want 0000", oe_now()); end
      tick();
      reset = 1'b0;
      tick();
      set_sample(4'b1111);
      strobe_edge();
      repeat (2) tick();
      n_checks++;
      if (pins_now() !== 4'h0) begin n_fail++; $display("FAIL after_reset_dig got %b want 0000", pins_now()); end
      n_checks++;
      if (oe_now() !== 4'h0) begin n_fail++; $display("FAIL after_reset_oe got %b want 0000", oe_now()); end
   endtask

   initial begin
      test_reset();
      test_d0();
      test_delay3();
      test_enable_drop();
      test_d_rewrite();
      test_other_addr_and_swap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
